wildcard_match_stage: RTL

WILDCARD_MATCH_STAGE -- requirements
Module: wildcard_match_stage

---
 rtl/wildcard_match_pkg.sv | 13 +
 rtl/wildcard_match_stage_cmp.sv | 19 +
 rtl/wildcard_match_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/wildcard_match_pkg.sv
// Shared types and default widths for the wildcard match stage family.
package wildcard_match_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefCntW  = 16;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/wildcard_match_stage_cmp.sv
// Combinational masked compare: care bits are compared, cleared care bits are wildcards.
module wildcard_cmp
    import wildcard_match_pkg::*;
#(
    parameter int unsigned W = DefDataW
) (
    input  logic [W-1:0] data_i,
    input  logic [W-1:0] value_i,
    input  logic [W-1:0] care_i,
    output logic         eq_o,
    output logic         neq_o
);

    always_comb begin
        eq_o  = (((data_i ^ value_i) & care_i) == '0);
        neq_o = ~eq_o;
    end

endmodule

// File: rtl/wildcard_match_stage.sv
// Streaming wildcard-compare stage: tags each beat with eq/neq through a 2-entry skid buffer
// and counts delivered matching beats.
module wildcard_match_stage
    import wildcard_match_pkg::*;
#(
    parameter int unsigned P_W     = DefDataW,
    parameter int unsigned P_CNT_W = DefCntW
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cfg_we,
    input  logic [P_W-1:0]     i_cfg_value,
    input  logic [P_W-1:0]     i_cfg_care,
    input  logic               i_clr_cnt,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [P_W-1:0]     i_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [P_W-1:0]     o_data,
    output logic               o_eq,
    output logic               o_neq,
    output logic [P_CNT_W-1:0] o_match_cnt,
    output logic               o_busy
);

    skid_state_e        state_q, state_d;
    logic [P_W-1:0]     value_q, value_d;
    logic [P_W-1:0]     care_q, care_d;
    logic [P_W-1:0]     out_data_q, out_data_d;
    logic               out_eq_q, out_eq_d;
    logic               out_neq_q, out_neq_d;
    logic [P_W-1:0]     skid_data_q, skid_data_d;
    logic               skid_eq_q, skid_eq_d;
    logic               skid_neq_q, skid_neq_d;
    logic [P_CNT_W-1:0] cnt_q, cnt_d;

    logic in_eq, in_neq;
    logic accept, take;

    wildcard_cmp #(
        .W (P_W)
    ) u_cmp (
        .data_i  (i_data),
        .value_i (value_q),
        .care_i  (care_q),
        .eq_o    (in_eq),
        .neq_o   (in_neq)
    );

    // Both handshakes are masked while reset is asserted so nothing completes in that cycle.
    assign o_ready     = i_rst_n && (state_q != StTwo);
    assign o_valid     = i_rst_n && (state_q != StEmpty);
    assign o_busy      = (state_q != StEmpty);
    assign o_data      = out_data_q;
    assign o_eq        = out_eq_q;
    assign o_neq       = out_neq_q;
    assign o_match_cnt = cnt_q;

    assign accept = i_valid && o_ready;
    assign take   = o_valid && i_ready;

    always_comb begin
        value_d = value_q;
        care_d  = care_q;
        if (i_cfg_we) begin
            value_d = i_cfg_value;
            care_d  = i_cfg_care;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_eq_d    = out_eq_q;
        out_neq_d   = out_neq_q;
        skid_data_d = skid_data_q;
        skid_eq_d   = skid_eq_q;
        skid_neq_d  = skid_neq_q;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d    = StOne;
                    out_data_d = i_data;
                    out_eq_d   = in_eq;
                    out_neq_d  = in_neq;
                end
            end
            StOne: begin
                if (accept && take) begin
                    out_data_d = i_data;
                    out_eq_d   = in_eq;
                    out_neq_d  = in_neq;
                end else if (accept) begin
                    state_d     = StTwo;
                    skid_data_d = i_data;
                    skid_eq_d   = in_eq;
                    skid_neq_d  = in_neq;
                end else if (take) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (take) begin
                    state_d    = StOne;
                    out_data_d = skid_data_q;
                    out_eq_d   = skid_eq_q;
                    out_neq_d  = skid_neq_q;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Clear wins over a simultaneous counted handshake; increment saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr_cnt) begin
            cnt_d = '0;
        end else if (take && out_eq_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StEmpty;
            value_q     <= '0;
            care_q      <= '0;
            out_data_q  <= '0;
            out_eq_q    <= 1'b0;
            out_neq_q   <= 1'b0;
            skid_data_q <= '0;
            skid_eq_q   <= 1'b0;
            skid_neq_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            care_q      <= care_d;
            out_data_q  <= out_data_d;
            out_eq_q    <= out_eq_d;
            out_neq_q   <= out_neq_d;
            skid_data_q <= skid_data_d;
            skid_eq_q   <= skid_eq_d;
            skid_neq_q  <= skid_neq_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
